// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// data_cache : direct-mapped, write-back, write-allocate byte data cache
// Rev 1.0    : initial release
// ============================================================================
module data_cache #(
   parameter int INDEX_BITS  = 3,
   parameter int OFFSET_BITS = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [5:0]  MEM_ADDRESS,
   output logic [31:0] MEM_WRITEDATA,
   input  logic [31:0] MEM_READDATA,
   input  logic        MEM_BUSYWAIT
);

   localparam int TAG_BITS = 8 - INDEX_BITS - OFFSET_BITS;
   localparam int LINES    = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  first_q;
   logic [31:0]           data_q [LINES];
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [LINES-1:0]      valid_q;
   logic [LINES-1:0]      dirty_q;
   logic [31:0]           fill_q;
   logic [7:0]            rdata_q;

   logic [TAG_BITS-1:0]   addr_tag;
   logic [INDEX_BITS-1:0] addr_idx;
   logic [OFFSET_BITS-1:0] addr_off;
   logic                  hit;
   logic                  rd_hit;
   logic                  wr_hit;
   logic                  xfer_done;
   logic [7:0]            sel_byte;

   assign addr_tag = ADDRESS[7 -: TAG_BITS];
   assign addr_idx = ADDRESS[OFFSET_BITS +: INDEX_BITS];
   assign addr_off = ADDRESS[OFFSET_BITS-1:0];

   assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
   assign wr_hit   = (state_q == IDLE) && WRITE && hit;
   // A simultaneous READ and WRITE is serviced as a store.
   assign rd_hit   = (state_q == IDLE) && READ && !WRITE && hit;
   assign sel_byte = data_q[addr_idx][{addr_off, 3'b000} +: 8];
   // The cycle that issues a memory request never completes it.
   assign xfer_done = !first_q && !MEM_BUSYWAIT;

   assign READDATA = rd_hit ? sel_byte : rdata_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         first_q <= 1'b0;
         valid_q <= '0;
         dirty_q <= '0;
         rdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         first_q <= (state_d != state_q);
         if (rd_hit) begin
            rdata_q <= sel_byte;
         end
         if (state_q == UPDATE) begin
            valid_q[addr_idx] <= 1'b1;
            dirty_q[addr_idx] <= 1'b0;
         end else if (wr_hit) begin
            dirty_q[addr_idx] <= 1'b1;
         end
      end
   end

   // Line payload and tags survive reset; only valid/dirty are cleared.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         if (state_q == UPDATE) begin
            data_q[addr_idx] <= fill_q;
            tag_q[addr_idx]  <= addr_tag;
         end else if (wr_hit) begin
            data_q[addr_idx][{addr_off, 3'b000} +: 8] <= WRITEDATA;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if ((state_q == FETCH) && xfer_done) begin
         fill_q <= MEM_READDATA;
      end
   end

   always_comb begin
      state_d       = state_q;
      BUSYWAIT      = 1'b1;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = 6'h00;
      MEM_WRITEDATA = 32'h0000_0000;
      case (state_q)
         IDLE: begin
            BUSYWAIT = 1'b0;
            if ((READ || WRITE) && !hit) begin
               BUSYWAIT = 1'b1;
               state_d  = (valid_q[addr_idx] && dirty_q[addr_idx]) ? WRITEBACK : FETCH;
            end
         end
         WRITEBACK: begin
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {tag_q[addr_idx], addr_idx};
            MEM_WRITEDATA = data_q[addr_idx];
            if (xfer_done) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = {addr_tag, addr_idx};
            if (xfer_done) begin
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// tb_data_cache : directed self-checking bench with a latency-programmable
//                 block memory model
// Rev 1.0       : initial release
// ============================================================================
module tb_data_cache;

   logic        CLK;
   logic        RESET;
   logic        READ;
   logic        WRITE;
   logic [7:0]  ADDRESS;
   logic [7:0]  WRITEDATA;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   int n_tests = 0;
   int n_fail  = 0;

   // memory model state
   logic [31:0] mem [64];
   int          mem_lat = 2;
   int          rd_cnt  = 0;
   int          wr_cnt  = 0;
   int          seq_no  = 0;
   int          rd_seq  = 0;
   int          wr_seq  = 0;
   logic [5:0]  last_rd_addr = 6'h3f;
   logic [5:0]  last_wr_addr = 6'h3f;
   logic [31:0] last_wr_data = 32'h0;
   bit          both_high = 1'b0;

   data_cache dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .READ         (READ),
      .WRITE        (WRITE),
      .ADDRESS      (ADDRESS),
      .WRITEDATA    (WRITEDATA),
      .READDATA     (READDATA),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_WRITE    (MEM_WRITE),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (MEM_READ && MEM_WRITE) both_high = 1'b1;
   end

   // Memory acts 2 time units after each posedge. A request seen first keeps
   // MEM_BUSYWAIT low, so the issue cycle carries no busy indication; it then
   // holds busy for (mem_lat-1) cycles and completes, giving mem_lat cycles
   // of FETCH/WRITEBACK after the issue cycle.
   initial begin : mem_model
      int          cnt;
      bit          active;
      bit          is_wr;
      logic [5:0]  a;
      logic [31:0] wd;
      for (int i = 0; i < 64; i++) begin
         mem[i] = {8'(i) + 8'h30, 8'(i) + 8'h20, 8'(i) + 8'h10, 8'(i)};
      end
      mem[0] = 32'h4433_2211;
      mem[1] = 32'hA3A2_A1A0;
      mem[8] = 32'h8877_6655;
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = 32'h0;
      active = 1'b0;
      cnt = 0; is_wr = 1'b0; a = '0; wd = '0;
      forever begin
         @(posedge CLK);
         #2;
         if (RESET) begin
            active = 1'b0;
            MEM_BUSYWAIT = 1'b0;
         end else if (active) begin
            if (cnt > 1) begin
               MEM_BUSYWAIT = 1'b1;
               cnt--;
            end else begin
               MEM_BUSYWAIT = 1'b0;
               active = 1'b0;
               if (is_wr) mem[a] = wd;
               else       MEM_READDATA = mem[a];
            end
         end else if (MEM_READ || MEM_WRITE) begin
            active = 1'b1;
            cnt    = mem_lat;
            a      = MEM_ADDRESS;
            is_wr  = MEM_WRITE;
            wd     = MEM_WRITEDATA;
            seq_no++;
            if (is_wr) begin
               wr_cnt++; wr_seq = seq_no; last_wr_addr = a; last_wr_data = wd;
            end else begin
               rd_cnt++; rd_seq = seq_no; last_rd_addr = a;
               MEM_READDATA = 32'hDEAD_BEEF;
            end
         end
      end
   end

   // One CPU access held until BUSYWAIT falls; stall = BUSYWAIT-high cycles.
   task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                            input logic [7:0] wdata, output int stall,
                            output logic [7:0] rdata, output bit tmo);
      @(posedge CLK); #1;
      READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
      stall = 0; tmo = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (!BUSYWAIT) begin
            tmo = 1'b0;
            break;
         end
         stall++;
      end
      rdata = READDATA;
      @(posedge CLK); #1;
      READ = 1'b0; WRITE = 1'b0;
   endtask

   task automatic test_reset;
      @(posedge CLK); #1; RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1; RESET = 1'b0;
      @(negedge CLK);
      n_tests++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busywait got %b want 0", BUSYWAIT); end
      n_tests++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got %b want 0", MEM_READ); end
      n_tests++; if (MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %b want 0", MEM_WRITE); end
      n_tests++; if (MEM_ADDRESS !== 6'h00) begin n_fail++; $display("FAIL reset_mem_address got %h want 00", MEM_ADDRESS); end
      n_tests++; if (MEM_WRITEDATA !== 32'h0) begin n_fail++; $display("FAIL reset_mem_writedata got %h want 0", MEM_WRITEDATA); end
      n_tests++; if (READDATA !== 8'h00) begin n_fail++; $display("FAIL reset_readdata got %h want 00", READDATA); end
   endtask

   task automatic test_clean_miss;
      int st; logic [7:0] rd; bit tmo;
      mem_lat = 2;
      do_access(1'b1, 1'b0, 8'h00, 8'h00, st, rd, tmo);
      n_tests++; if (tmo) begin n_fail++; $display("FAIL miss0_timeout got stall %0d want completion", st); end
      n_tests++; if (last_rd_addr !== 6'h00 || rd_cnt != 1) begin n_fail++; $display("FAIL miss0_fetch got addr %h cnt %0d want 00 1", last_rd_addr, rd_cnt); end
      n_tests++; if (rd !== 8'h11) begin n_fail++; $display("FAIL miss0_readdata got %h want 11", rd); end
      n_tests++; if (st != 5) begin n_fail++; $display("FAIL miss0_stall got %0d want 5", st); end
      n_tests++; if (wr_cnt != 0) begin n_fail++; $display("FAIL miss0_no_writeback got %0d want 0", wr_cnt); end
   endtask

   task automatic test_read_hit;
      int st; logic [7:0] rd; bit tmo;
      do_access(1'b1, 1'b0, 8'h03, 8'h00, st, rd, tmo);
      n_tests++; if (st != 0 || tmo) begin n_fail++; $display("FAIL hit3_stall got %0d want 0", st); end
      n_tests++; if (rd !== 8'h44) begin n_fail++; $display("FAIL hit3_readdata got %h want 44", rd); end
      n_tests++; if (rd_cnt != 1) begin n_fail++; $display("FAIL hit3_no_fetch got %0d want 1", rd_cnt); end
      @(negedge CLK);
      n_tests++; if (READDATA !== 8'h44) begin n_fail++; $display("FAIL readdata_hold got %h want 44", READDATA); end
   endtask

   task automatic test_write_hit;
      int st; logic [7:0] rd; bit tmo;
      do_access(1'b0, 1'b1, 8'h01, 8'hAB, st, rd, tmo);
      n_tests++; if (st != 0 || tmo) begin n_fail++; $display("FAIL whit_stall got %0d want 0", st); end
      n_tests++; if (rd_cnt != 1 || wr_cnt != 0) begin n_fail++; $display("FAIL whit_no_mem got rd %0d wr %0d want 1 0", rd_cnt, wr_cnt); end
      do_access(1'b1, 1'b0, 8'h01, 8'h00, st, rd, tmo);
      n_tests++; if (rd !== 8'hAB || st != 0) begin n_fail++; $display("FAIL whit_readback got %h stall %0d want ab 0", rd, st); end
      do_access(1'b1, 1'b0, 8'h02, 8'h00, st, rd, tmo);
      n_tests++; if (rd !== 8'h33) begin n_fail++; $display("FAIL whit_neighbour got %h want 33", rd); end
   endtask

   task automatic test_write_miss;
      int st; logic [7:0] rd; bit tmo;
      mem_lat = 1;
      do_access(1'b0, 1'b1, 8'h05, 8'hCC, st, rd, tmo);
      n_tests++; if (st != 4 || tmo) begin n_fail++; $display("FAIL wmiss_stall got %0d want 4", st); end
      n_tests++; if (last_rd_addr !== 6'h01 || wr_cnt != 0) begin n_fail++; $display("FAIL wmiss_fetch got addr %h wr %0d want 01 0", last_rd_addr, wr_cnt); end
      do_access(1'b1, 1'b0, 8'h05, 8'h00, st, rd, tmo);
      n_tests++; if (rd !== 8'hCC) begin n_fail++; $display("FAIL wmiss_byte got %h want cc", rd); end
      do_access(1'b1, 1'b0, 8'h04, 8'h00, st, rd, tmo);
      n_tests++; if (rd !== 8'hA0) begin n_fail++; $display("FAIL wmiss_fill got %h want a0", rd); end
   endtask

   task automatic test_writeback;
      int st; logic [7:0] rd; bit tmo;
      mem_lat = 3;
      do_access(1'b1, 1'b0, 8'h20, 8'h00, st, rd, tmo);
      n_tests++; if (wr_cnt != 1 || last_wr_addr !== 6'h00) begin n_fail++; $display("FAIL wb_addr got %h cnt %0d want 00 1", last_wr_addr, wr_cnt); end
      n_tests++; if (last_wr_data !== 32'h4433_AB11) begin n_fail++; $display("FAIL wb_data got %h want 4433ab11", last_wr_data); end
      n_tests++; if (last_rd_addr !== 6'h08 || rd_seq <= wr_seq) begin n_fail++; $display("FAIL wb_then_fetch got addr %h rseq %0d wseq %0d want 08 after", last_rd_addr, rd_seq, wr_seq); end
      n_tests++; if (both_high) begin n_fail++; $display("FAIL wb_exclusive got both-high want never"); end
      n_tests++; if (rd !== 8'h55) begin n_fail++; $display("FAIL wb_readdata got %h want 55", rd); end
      n_tests++; if (st != 10 || tmo) begin n_fail++; $display("FAIL wb_stall got %0d want 10", st); end
      n_tests++; if (mem[0] !== 32'h4433_AB11) begin n_fail++; $display("FAIL wb_memory got %h want 4433ab11", mem[0]); end
   endtask

   task automatic test_reset_mid_fetch;
      int st; logic [7:0] rd; bit tmo; bit seen; int rc;
      mem_lat = 5;
      @(posedge CLK); #1;
      READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h40;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (MEM_READ) begin seen = 1'b1; break; end
      end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL rst_fetch_start got no MEM_READ want MEM_READ"); end
      @(posedge CLK); #1; RESET = 1'b1; READ = 1'b0;
      @(posedge CLK); #1; RESET = 1'b0;
      @(negedge CLK);
      n_tests++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL rst_abort got rd %b wr %b want 0 0", MEM_READ, MEM_WRITE); end
      n_tests++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL rst_busywait got %b want 0", BUSYWAIT); end
      n_tests++; if (READDATA !== 8'h00) begin n_fail++; $display("FAIL rst_readdata got %h want 00", READDATA); end
      mem_lat = 2;
      rc = rd_cnt;
      do_access(1'b1, 1'b0, 8'h00, 8'h00, st, rd, tmo);
      n_tests++; if (rd_cnt != rc + 1 || st != 5) begin n_fail++; $display("FAIL rst_invalidated got fetches %0d stall %0d want %0d 5", rd_cnt, st, rc + 1); end
      n_tests++; if (rd !== 8'h11) begin n_fail++; $display("FAIL rst_refill got %h want 11", rd); end
   endtask

   task automatic test_latency_sweep;
      int st; logic [7:0] rd; bit tmo; logic [7:0] addr; logic [7:0] exp;
      for (int lat = 1; lat <= 5; lat++) begin
         mem_lat = lat;
         addr = 8'h09 + 8'(4 * (lat - 1));
         exp  = 8'(lat + 1) + 8'h10;
         do_access(1'b1, 1'b0, addr, 8'h00, st, rd, tmo);
         // detect cycle + issue cycle + lat + update
         n_tests++; if (st != lat + 3 || tmo) begin n_fail++; $display("FAIL sweep_stall lat %0d got %0d want %0d", lat, st, lat + 3); end
         n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL sweep_data lat %0d got %h want %h", lat, rd, exp); end
      end
   endtask

   task automatic test_back_to_back;
      int st; logic [7:0] rd; bit tmo;
      $display("[TB] note: READ and WRITE driven together (protocol error), expecting store");
      do_access(1'b1, 1'b1, 8'h09, 8'h5A, st, rd, tmo);
      n_tests++; if (st != 0 || tmo) begin n_fail++; $display("FAIL rw_stall got %0d want 0", st); end
      do_access(1'b1, 1'b0, 8'h09, 8'h00, st, rd, tmo);
      n_tests++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL rw_as_write got %h want 5a", rd); end
      do_access(1'b1, 1'b0, 8'h0A, 8'h00, st, rd, tmo);
      n_tests++; if (rd !== 8'h22) begin n_fail++; $display("FAIL rw_neighbour got %h want 22", rd); end
   endtask

   initial begin
      RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
      test_reset();
      test_clean_miss();
      test_read_hit();
      test_write_hit();
      test_write_miss();
      test_writeback();
      test_reset_mid_fetch();
      test_latency_sweep();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
